minirisc_fetch_queue: RTL

//  Instruction fetch queue directly upstream of the tt_um_minirisc decode/execute core.

---
 rtl/minirisc_fetch_queue.sv | 81 ++++++++
 1 files changed

// File: rtl/minirisc_fetch_queue.sv
// Instruction fetch queue between the pad-side word source and the minirisc core.
// Latency: a word accepted at edge N is presented on out_valid/out_data after edge N.
// Backpressure: in_ready drops only when full (no pass-through); out_ready only pops.
module minirisc_fetch_queue #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             push;
  logic             pop;

  // Handshake qualifiers; full is judged from occupancy alone so in_ready ignores out_ready.
  always_comb begin
    full      = (count == CNT_W'(DEPTH));
    in_ready  = ~full;
    out_valid = (count != '0);
    out_data  = out_valid ? mem[rd_ptr] : '0;
    push      = ena & in_valid & in_ready;
    pop       = ena & out_valid & out_ready;
  end

  // Storage write; a flush in the same cycle drops the offered word.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointer, occupancy and sticky overflow state; flush outranks push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (ena) begin
      if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
        if (in_valid && !in_ready) begin
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule
